// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the microprogrammed 8-bit CPU datapath.
//   - control-word field positions and a decoded control-word struct
//   - ALU function encodings (fs)
//   - processor status word bit indices, psw = {z,n,c,v}
package cpu_pkg;

  localparam int CW_W  = 13;
  localparam int OPS_W = 9;

  // Control-word field positions
  localparam int CW_DA_HI = 12;
  localparam int CW_DA_LO = 11;
  localparam int CW_AA_HI = 10;
  localparam int CW_AA_LO = 9;
  localparam int CW_BA_HI = 8;
  localparam int CW_BA_LO = 7;
  localparam int CW_MB    = 6;
  localparam int CW_FS_HI = 5;
  localparam int CW_FS_LO = 3;
  localparam int CW_MD    = 2;
  localparam int CW_RW    = 1;
  localparam int CW_MW    = 0;

  // ALU function encodings
  localparam logic [2:0] FS_PASS = 3'b000;
  localparam logic [2:0] FS_ADD  = 3'b001;
  localparam logic [2:0] FS_SUB  = 3'b010;
  localparam logic [2:0] FS_INC  = 3'b011;
  localparam logic [2:0] FS_AND  = 3'b100;
  localparam logic [2:0] FS_OR   = 3'b101;
  localparam logic [2:0] FS_XOR  = 3'b110;
  localparam logic [2:0] FS_SHR  = 3'b111;

  // psw bit indices
  localparam int PSW_Z = 3;
  localparam int PSW_N = 2;
  localparam int PSW_C = 1;
  localparam int PSW_V = 0;

  typedef struct packed {
    logic [1:0] da;
    logic [1:0] aa;
    logic [1:0] ba;
    logic       mb;
    logic [2:0] fs;
    logic       md;
    logic       rw;
    logic       mw;
  } cw_t;

  function automatic cw_t decode_cw(input logic [CW_W-1:0] cw);
    cw_t d;
    d.da = cw[CW_DA_HI:CW_DA_LO];
    d.aa = cw[CW_AA_HI:CW_AA_LO];
    d.ba = cw[CW_BA_HI:CW_BA_LO];
    d.mb = cw[CW_MB];
    d.fs = cw[CW_FS_HI:CW_FS_LO];
    d.md = cw[CW_MD];
    d.rw = cw[CW_RW];
    d.mw = cw[CW_MW];
    return d;
  endfunction

endpackage

// File: rtl/cpu_dp_if.sv
// cpu_dp_if: bundle between the CPU controller / data memory and the datapath.
//   cw, ir_ops   : control word and operand field from the controller
//   dmem_rdata   : combinational read data for the current dmem_addr
//   dmem_addr/wdata/we : data-memory port driven by the datapath
//   psw          : registered status flags {z,n,c,v} back to the controller
// There is no handshake on this bundle: the controller issues one control
// word per cycle and the datapath always accepts it.
// Modports: master = controller/memory side, slave = datapath side.
interface cpu_dp_if #(
  parameter int bw = 8
);
  import cpu_pkg::*;

  logic [CW_W-1:0]  cw;
  logic [OPS_W-1:0] ir_ops;
  logic [bw-1:0]    dmem_rdata;
  logic [bw-1:0]    dmem_addr;
  logic [bw-1:0]    dmem_wdata;
  logic             dmem_we;
  logic [3:0]       psw;

  modport master (
    output cw, ir_ops, dmem_rdata,
    input  dmem_addr, dmem_wdata, dmem_we, psw
  );

  modport slave (
    input  cw, ir_ops, dmem_rdata,
    output dmem_addr, dmem_wdata, dmem_we, psw
  );

endinterface

// File: rtl/cpu_alu.sv
// cpu_alu: combinational 8-function ALU.
//   a_i, b_i  : operands
//   fs_i      : function select (FS_* in cpu_pkg)
//   result_o  : result modulo 2^bw
//   z_o, n_o, c_o, v_o : zero, negative, carry, signed overflow
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int bw = 8
) (
  input  logic [bw-1:0] a_i,
  input  logic [bw-1:0] b_i,
  input  logic [2:0]    fs_i,
  output logic [bw-1:0] result_o,
  output logic          z_o,
  output logic          n_o,
  output logic          c_o,
  output logic          v_o
);

  localparam int MSB = bw - 1;

  logic [bw:0]   sum;
  logic [bw-1:0] res;
  logic          c;
  logic          v;

  always_comb begin
    sum = '0;
    res = '0;
    c   = 1'b0;
    v   = 1'b0;
    case (fs_i)
      FS_PASS: res = a_i;
      FS_ADD: begin
        sum = {1'b0, a_i} + {1'b0, b_i};
        res = sum[bw-1:0];
        c   = sum[bw];
        // Like-signed operands producing an opposite-signed result
        v   = (a_i[MSB] == b_i[MSB]) && (res[MSB] != a_i[MSB]);
      end
      FS_SUB: begin
        // Two's-complement subtract; carry-out of 1 means no borrow
        sum = {1'b0, a_i} + {1'b0, ~b_i} + {{bw{1'b0}}, 1'b1};
        res = sum[bw-1:0];
        c   = sum[bw];
        v   = (a_i[MSB] != b_i[MSB]) && (res[MSB] != a_i[MSB]);
      end
      FS_INC: begin
        sum = {1'b0, a_i} + {{bw{1'b0}}, 1'b1};
        res = sum[bw-1:0];
        c   = sum[bw];
        // Adding +1 overflows only when a positive A wraps to negative
        v   = ~a_i[MSB] & res[MSB];
      end
      FS_AND: res = a_i & b_i;
      FS_OR:  res = a_i | b_i;
      FS_XOR: res = a_i ^ b_i;
      FS_SHR: begin
        res = a_i >> 1;
        c   = a_i[0];
      end
      default: res = a_i;
    endcase
  end

  assign result_o = res;
  assign z_o      = (res == '0);
  assign n_o      = res[MSB];
  assign c_o      = c;
  assign v_o      = v;

endmodule

// File: rtl/cpu_dp.sv
// cpu_dp: datapath of the microprogrammed 8-bit CPU.
//   clk  : system clock, all state updates on the rising edge
//   rst  : synchronous active-high reset, clears R0..R3 and psw
//   bus  : cpu_dp_if slave modport
//          cw, ir_ops, dmem_rdata in; dmem_addr, dmem_wdata, dmem_we, psw out
// Contains the 4-entry register file, the ALU and the psw register.
module cpu_dp
  import cpu_pkg::*;
#(
  parameter int bw = 8
) (
  input  logic       clk,
  input  logic       rst,
  cpu_dp_if.slave    bus
);

  cw_t           ctl;
  logic [bw-1:0] regs_q [4];
  logic [bw-1:0] regs_d [4];
  logic [3:0]    psw_q;
  logic [3:0]    psw_d;

  logic [bw-1:0] a_op;
  logic [bw-1:0] b_reg;
  logic [bw-1:0] b_op;
  logic [bw-1:0] alu_res;
  logic          alu_z, alu_n, alu_c, alu_v;
  logic [bw-1:0] wr_data;
  logic          unused_ops;

  assign ctl = decode_cw(bus.cw);

  // Combinational register reads; a same-cycle write is seen next cycle
  assign a_op  = regs_q[ctl.aa];
  assign b_reg = regs_q[ctl.ba];
  assign b_op  = ctl.mb ? bus.ir_ops[bw-1:0] : b_reg;

  // Only the low bw bits of the operand field form the immediate
  assign unused_ops = ^bus.ir_ops;

  cpu_alu #(.bw(bw)) u_alu (
    .a_i      (a_op),
    .b_i      (b_op),
    .fs_i     (ctl.fs),
    .result_o (alu_res),
    .z_o      (alu_z),
    .n_o      (alu_n),
    .c_o      (alu_c),
    .v_o      (alu_v)
  );

  assign wr_data = ctl.md ? bus.dmem_rdata : alu_res;

  always_comb begin
    regs_d = regs_q;
    psw_d  = psw_q;
    if (ctl.rw) begin
      regs_d[ctl.da] = wr_data;
      // Memory loads leave the flags alone
      if (!ctl.md) begin
        psw_d[PSW_Z] = alu_z;
        psw_d[PSW_N] = alu_n;
        psw_d[PSW_C] = alu_c;
        psw_d[PSW_V] = alu_v;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= '0;
      psw_q <= '0;
    end else begin
      regs_q <= regs_d;
      psw_q  <= psw_d;
    end
  end

  // Memory port: address from A, write data is always the raw B register
  assign bus.dmem_addr  = a_op;
  assign bus.dmem_wdata = b_reg;
  assign bus.dmem_we    = ctl.mw & ~rst;
  assign bus.psw        = psw_q;

endmodule
